hpi_responder: RTL and testbench

//  Device-side responder for the 16-bit CY7C67200-style HPI bus driven by hpi_io_intf.

---
 rtl/hpi_responder_pkg.sv | 46 ++++
 rtl/hpi_responder_if.sv | 31 +++
 rtl/hpi_bus_sync.sv | 31 +++
 rtl/hpi_responder.sv | 183 ++++++++++++++++++
 tb/tb_hpi_responder.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hpi_responder_pkg.sv
// Shared types and constants for the HPI responder: register select codes,
// FSM states, status bit positions and the captured bus bundle.
package hpi_pkg;

    typedef enum logic [1:0] {
        HPI_DATA    = 2'b00,
        HPI_MAILBOX = 2'b01,
        HPI_ADDRESS = 2'b10,
        HPI_STATUS  = 2'b11
    } hpi_reg_e;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RD_FETCH = 2'b01,
        RD_DRIVE = 2'b10,
        WR_WAIT  = 2'b11
    } hpi_state_e;

    localparam int ST_D2H_FULL = 0;
    localparam int ST_D2H_OVR  = 1;
    localparam int ST_H2D_PEND = 2;

    // All asynchronous bus inputs travel through the synchroniser as one word
    // so that address and data stay aligned with the strobes.
    typedef struct packed {
        logic        cs_n;
        logic        rd_n;
        logic        wr_n;
        logic        rst_n;
        logic [1:0]  addr;
        logic [15:0] data;
    } hpi_bus_t;

    // Host-visible status word layout.
    function automatic logic [15:0] status_word(input logic h2d_pend,
                                                input logic d2h_ovr,
                                                input logic d2h_full);
        logic [15:0] w;
        w = 16'h0000;
        w[ST_H2D_PEND] = h2d_pend;
        w[ST_D2H_OVR]  = d2h_ovr;
        w[ST_D2H_FULL] = d2h_full;
        return w;
    endfunction

endpackage

// File: rtl/hpi_responder_if.sv
// HPI bus bundle. The shared data wire is resolved here from the host and
// device drive/enable pairs so each side only deals with plain variables.
interface hpi_if;

    wire  [15:0] OTG_DATA;
    logic [1:0]  OTG_ADDR;
    logic        OTG_CS_N;
    logic        OTG_RD_N;
    logic        OTG_WR_N;
    logic        OTG_RST_N;

    logic [15:0] host_data;
    logic        host_oe;
    logic [15:0] dev_data;
    logic        dev_oe;

    assign OTG_DATA = host_oe ? host_data : 16'bz;
    assign OTG_DATA = dev_oe  ? dev_data  : 16'bz;

    modport master (
        input  OTG_DATA, dev_oe,
        output OTG_ADDR, OTG_CS_N, OTG_RD_N, OTG_WR_N, OTG_RST_N,
        output host_data, host_oe
    );

    modport slave (
        input  OTG_DATA, OTG_ADDR, OTG_CS_N, OTG_RD_N, OTG_WR_N, OTG_RST_N,
        output dev_data, dev_oe
    );

endinterface

// File: rtl/hpi_bus_sync.sv
// Multi-stage synchroniser for the complete HPI input bundle. Strobes reset
// to their inactive (high) level so no access is seen coming out of reset.
module hpi_bus_sync
    import hpi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  hpi_bus_t bus_in,
    output hpi_bus_t bus_out
);

    localparam hpi_bus_t BUS_IDLE = '{cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1,
                                      rst_n: 1'b1, addr: 2'b00, data: 16'h0000};

    hpi_bus_t stages [SYNC_STAGES];

    // Shift the captured bus word down the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) stages[i] <= BUS_IDLE;
        end else begin
            stages[0] <= bus_in;
            for (int i = 1; i < SYNC_STAGES; i++) stages[i] <= stages[i-1];
        end
    end

    assign bus_out = stages[SYNC_STAGES-1];

endmodule

// File: rtl/hpi_responder.sv
// Device-side HPI responder: word RAM behind an auto-incrementing byte
// address register, host<->device mailboxes, status word and OTG_INT.
module hpi_responder
    import hpi_pkg::*;
#(
    parameter int MEM_AW      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic        Clk,
    input  logic        Reset_n,
    hpi_if.slave        otg,
    output logic        OTG_INT,
    output logic        mbx_h2d_valid,
    output logic [15:0] mbx_h2d_data,
    input  logic        mbx_h2d_ack,
    input  logic        mbx_d2h_wr,
    input  logic [15:0] mbx_d2h_data
);

    localparam int AW = MEM_AW + 1;

    hpi_bus_t    bus_raw, bus_s;
    logic        rd_prev, wr_prev;
    logic [15:0] data_prev;
    hpi_state_e  state;
    hpi_reg_e    reg_sel;
    logic [15:0] out_q, read_mux, ram_q;
    logic [AW-1:0] addr_reg;
    logic [15:0] d2h_word;
    logic        d2h_full, d2h_ovr;
    logic        soft_rst, rd_start, wr_start, rd_end, wr_commit, ram_we;
    logic [MEM_AW-1:0] ram_idx;
    logic [15:0] mem [0:(1<<MEM_AW)-1];

    assign bus_raw = '{cs_n: otg.OTG_CS_N, rd_n: otg.OTG_RD_N, wr_n: otg.OTG_WR_N,
                       rst_n: otg.OTG_RST_N, addr: otg.OTG_ADDR, data: otg.OTG_DATA};

    hpi_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .bus_in  (bus_raw),
        .bus_out (bus_s)
    );

    // One-cycle history of the synced strobes and data for edge detection
    // and for committing the word that was present while WR_N was low.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_prev   <= 1'b1;
            wr_prev   <= 1'b1;
            data_prev <= 16'h0000;
        end else begin
            rd_prev   <= bus_s.rd_n;
            wr_prev   <= bus_s.wr_n;
            data_prev <= bus_s.data;
        end
    end

    assign soft_rst  = !bus_s.rst_n;
    assign rd_start  = !bus_s.cs_n && !bus_s.rd_n && rd_prev && bus_s.wr_n;
    assign wr_start  = !bus_s.cs_n && !bus_s.wr_n && wr_prev && bus_s.rd_n;
    // A read ends normally when RD_N or CS_N goes high; a concurrent WR_N low
    // turns it into a void access without side effects.
    assign rd_end    = !soft_rst && (state == RD_DRIVE) && bus_s.wr_n &&
                       (bus_s.rd_n || bus_s.cs_n);
    // CS_N rising before (or with) WR_N aborts the write.
    assign wr_commit = !soft_rst && (state == WR_WAIT) && bus_s.wr_n &&
                       bus_s.rd_n && !bus_s.cs_n;
    assign ram_we    = wr_commit && (reg_sel == HPI_DATA);
    assign ram_idx   = addr_reg[MEM_AW:1];

    // Register-file view presented to the host during the fetch cycle.
    always_comb begin
        read_mux = 16'h0000;
        case (reg_sel)
            HPI_DATA:    read_mux = ram_q;
            HPI_MAILBOX: read_mux = d2h_word;
            HPI_ADDRESS: read_mux = 16'(addr_reg);
            HPI_STATUS:  read_mux = status_word(mbx_h2d_valid, d2h_ovr, d2h_full);
            default:     read_mux = 16'h0000;
        endcase
    end

    // Access sequencer: decodes strobe edges, fetches read data, waits for write end.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            reg_sel <= HPI_DATA;
            out_q   <= 16'h0000;
        end else if (soft_rst) begin
            state   <= IDLE;
            reg_sel <= HPI_DATA;
            out_q   <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_start) begin
                        reg_sel <= hpi_reg_e'(bus_s.addr);
                        state   <= RD_FETCH;
                    end else if (wr_start) begin
                        reg_sel <= hpi_reg_e'(bus_s.addr);
                        state   <= WR_WAIT;
                    end
                end
                RD_FETCH: begin
                    out_q <= read_mux;
                    state <= RD_DRIVE;
                end
                RD_DRIVE: begin
                    if (bus_s.rd_n || bus_s.cs_n || !bus_s.wr_n) state <= IDLE;
                end
                WR_WAIT: begin
                    if (bus_s.wr_n || bus_s.cs_n || !bus_s.rd_n) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Byte address register: host load, or +2 after each DATA access (wraps).
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            addr_reg <= '0;
        end else if (soft_rst) begin
            addr_reg <= '0;
        end else if (wr_commit && (reg_sel == HPI_ADDRESS)) begin
            addr_reg <= data_prev[AW-1:0];
        end else if ((wr_commit || rd_end) && (reg_sel == HPI_DATA)) begin
            addr_reg <= addr_reg + AW'(2);
        end
    end

    // Single-port word RAM with synchronous read; contents survive soft reset.
    always_ff @(posedge Clk) begin
        if (ram_we) mem[ram_idx] <= data_prev;
        ram_q <= mem[ram_idx];
    end

    // Mailboxes and status flags; local-side events win over host side effects.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mbx_h2d_valid <= 1'b0;
            mbx_h2d_data  <= 16'h0000;
            d2h_word      <= 16'h0000;
            d2h_full      <= 1'b0;
            d2h_ovr       <= 1'b0;
        end else if (soft_rst) begin
            mbx_h2d_valid <= 1'b0;
            mbx_h2d_data  <= 16'h0000;
            d2h_word      <= 16'h0000;
            d2h_full      <= 1'b0;
            d2h_ovr       <= 1'b0;
        end else begin
            if (wr_commit && (reg_sel == HPI_MAILBOX)) begin
                mbx_h2d_data  <= data_prev;
                mbx_h2d_valid <= 1'b1;
            end else if (mbx_h2d_ack) begin
                mbx_h2d_valid <= 1'b0;
            end

            if (mbx_d2h_wr) begin
                d2h_word <= mbx_d2h_data;
                d2h_full <= 1'b1;
            end else if (rd_end && (reg_sel == HPI_MAILBOX)) begin
                d2h_full <= 1'b0;
            end

            if (mbx_d2h_wr && d2h_full) begin
                d2h_ovr <= 1'b1;
            end else if (rd_end && (reg_sel == HPI_STATUS)) begin
                d2h_ovr <= 1'b0;
            end
        end
    end

    assign OTG_INT = d2h_full;

    // The bus is released in the same cycle the strobe end or soft reset is seen.
    assign otg.dev_oe   = (state == RD_DRIVE) && !bus_s.rd_n && !bus_s.cs_n &&
                          bus_s.wr_n && bus_s.rst_n;
    assign otg.dev_data = out_q;

endmodule

// File: tb/tb_hpi_responder.sv
// Self-checking bench for hpi_responder: directed vector table, hand-written
// mailbox/reset corner sequences, then randomized traffic against a model.
module tb_hpi_responder;
    import hpi_pkg::*;

    localparam int MEM_AW = 12;
    localparam int SYNC   = 2;
    localparam int AMOD   = 1 << (MEM_AW + 1);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        otg_int;
    logic        h2d_valid;
    logic [15:0] h2d_data;
    logic        h2d_ack;
    logic        d2h_wr;
    logic [15:0] d2h_data;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    hpi_if bus ();

    hpi_responder #(.MEM_AW(MEM_AW), .SYNC_STAGES(SYNC)) dut (
        .Clk           (clk),
        .Reset_n       (rst_n),
        .otg           (bus),
        .OTG_INT       (otg_int),
        .mbx_h2d_valid (h2d_valid),
        .mbx_h2d_data  (h2d_data),
        .mbx_h2d_ack   (h2d_ack),
        .mbx_d2h_wr    (d2h_wr),
        .mbx_d2h_data  (d2h_data)
    );

    typedef struct {
        bit          wr;
        logic [1:0]  rsel;
        logic [15:0] data;   // write value, or expected read value
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic host_write(input logic [1:0] rsel, input logic [15:0] d, input bit co_ack);
        bus.OTG_ADDR  = rsel;
        bus.host_data = d;
        bus.host_oe   = 1'b1;
        bus.OTG_CS_N  = 1'b0;
        @(negedge clk);
        bus.OTG_WR_N = 1'b0;
        repeat (SYNC + 3) @(negedge clk);
        bus.OTG_WR_N = 1'b1;
        for (int i = 0; i < SYNC + 2; i++) begin
            h2d_ack = co_ack && (i == SYNC);
            @(negedge clk);
        end
        h2d_ack      = 1'b0;
        bus.OTG_CS_N = 1'b1;
        bus.host_oe  = 1'b0;
        repeat (SYNC + 2) @(negedge clk);
    endtask

    task automatic host_read(input logic [1:0] rsel, output logic [15:0] d, output logic oe,
                             input bit co_d2h, input logic [15:0] d2h_v);
        bus.OTG_ADDR = rsel;
        bus.host_oe  = 1'b0;
        bus.OTG_CS_N = 1'b0;
        @(negedge clk);
        bus.OTG_RD_N = 1'b0;
        repeat (SYNC + 3) @(negedge clk);
        d  = bus.OTG_DATA;
        oe = bus.dev_oe;
        bus.OTG_RD_N = 1'b1;
        for (int i = 0; i < SYNC + 2; i++) begin
            d2h_wr   = co_d2h && (i == SYNC);
            d2h_data = d2h_v;
            @(negedge clk);
        end
        d2h_wr       = 1'b0;
        bus.OTG_CS_N = 1'b1;
        repeat (SYNC + 2) @(negedge clk);
    endtask

    task automatic read_chk(input string name, input logic [1:0] rsel, input logic [15:0] exp);
        logic [15:0] d;
        logic        oe;
        host_read(rsel, d, oe, 1'b0, 16'h0);
        check({name, "_oe"}, oe, 1'b1);
        check(name, d, exp);
    endtask

    task automatic d2h_post(input logic [15:0] v);
        d2h_data = v;
        d2h_wr   = 1'b1;
        @(negedge clk);
        d2h_wr = 1'b0;
    endtask

    // Reference model state for the randomized phase.
    logic [15:0] m_mem [int];
    int          m_addr;
    logic [15:0] m_d2h;
    bit          m_d2h_known, m_full, m_ovr, m_h2d_valid;
    logic [15:0] m_h2d;

    vec_t vecs [$];

    initial begin
        logic [15:0] rd;
        logic        oe;
        logic [15:0] v, exp_w;

        rst_n = 1'b0;
        bus.OTG_ADDR = 2'b00; bus.OTG_CS_N = 1'b1; bus.OTG_RD_N = 1'b1;
        bus.OTG_WR_N = 1'b1;  bus.OTG_RST_N = 1'b1;
        bus.host_data = 16'h0; bus.host_oe = 1'b0;
        h2d_ack = 1'b0; d2h_wr = 1'b0; d2h_data = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_oe", bus.dev_oe, 1'b0);
        check("rst_int", otg_int, 1'b0);
        check("rst_h2d_valid", h2d_valid, 1'b0);
        check("rst_h2d_data", h2d_data, 16'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        read_chk("rst_status", 2'b11, 16'h0000);
        read_chk("rst_addr", 2'b10, 16'h0000);

        // Directed register-map vectors: RAM access, increment, wrap.
        vecs.push_back('{1, 2'b10, 16'h0010});
        vecs.push_back('{1, 2'b00, 16'hBEEF});
        vecs.push_back('{1, 2'b00, 16'h1234});
        vecs.push_back('{1, 2'b10, 16'h0010});
        vecs.push_back('{0, 2'b00, 16'hBEEF});
        vecs.push_back('{0, 2'b00, 16'h1234});
        vecs.push_back('{0, 2'b10, 16'h0014});
        vecs.push_back('{1, 2'b10, 16'h1FFE});
        vecs.push_back('{1, 2'b00, 16'hA5A5});
        vecs.push_back('{0, 2'b10, 16'h0000});
        vecs.push_back('{1, 2'b10, 16'h1FFE});
        vecs.push_back('{0, 2'b00, 16'hA5A5});
        vecs.push_back('{0, 2'b10, 16'h0000});
        vecs.push_back('{1, 2'b11, 16'hFFFF});
        vecs.push_back('{0, 2'b11, 16'h0000});
        foreach (vecs[i]) begin
            if (vecs[i].wr) host_write(vecs[i].rsel, vecs[i].data, 1'b0);
            else read_chk($sformatf("vec%0d", i), vecs[i].rsel, vecs[i].data);
        end

        // Device-to-host mailbox and interrupt.
        check("int_before_post", otg_int, 1'b0);
        d2h_post(16'h00C3);
        check("int_after_post", otg_int, 1'b1);
        read_chk("status_full", 2'b11, 16'h0001);
        read_chk("mbx_read", 2'b01, 16'h00C3);
        check("int_after_read", otg_int, 1'b0);
        read_chk("status_empty", 2'b11, 16'h0000);

        // Overrun, read-to-clear, and device write racing a host read end.
        d2h_post(16'h0011);
        @(negedge clk);
        d2h_post(16'h0022);
        read_chk("status_ovr", 2'b11, 16'h0003);
        read_chk("status_ovr_clr", 2'b11, 16'h0001);
        host_read(2'b01, rd, oe, 1'b1, 16'h0077);
        check("race_rd_oe", oe, 1'b1);
        check("race_rd_data", rd, 16'h0022);
        check("race_int", otg_int, 1'b1);
        read_chk("race_status", 2'b11, 16'h0003);
        read_chk("race_mbx", 2'b01, 16'h0077);
        check("race_int_clr", otg_int, 1'b0);
        read_chk("race_status_clr", 2'b11, 16'h0000);

        // Host-to-device mailbox, ack racing a second write.
        host_write(2'b01, 16'h5A5A, 1'b0);
        check("h2d_valid", h2d_valid, 1'b1);
        check("h2d_data", h2d_data, 16'h5A5A);
        read_chk("status_pend", 2'b11, 16'h0004);
        host_write(2'b01, 16'h0001, 1'b1);
        check("h2d_race_valid", h2d_valid, 1'b1);
        check("h2d_race_data", h2d_data, 16'h0001);
        h2d_ack = 1'b1;
        @(negedge clk);
        h2d_ack = 1'b0;
        @(negedge clk);
        check("h2d_ack_clr", h2d_valid, 1'b0);
        read_chk("status_pend_clr", 2'b11, 16'h0000);

        // Simultaneous RD_N and WR_N is not an access.
        bus.OTG_ADDR = 2'b10; bus.OTG_CS_N = 1'b0;
        @(negedge clk);
        bus.OTG_RD_N = 1'b0; bus.OTG_WR_N = 1'b0;
        repeat (SYNC + 4) @(negedge clk);
        check("both_low_oe", bus.dev_oe, 1'b0);
        bus.OTG_RD_N = 1'b1; bus.OTG_WR_N = 1'b1; bus.OTG_CS_N = 1'b1;
        repeat (SYNC + 3) @(negedge clk);

        // Host soft reset in the middle of a DATA write.
        host_write(2'b10, 16'h0020, 1'b0);
        host_write(2'b00, 16'h1111, 1'b0);
        host_write(2'b10, 16'h0020, 1'b0);
        bus.OTG_ADDR = 2'b00; bus.host_data = 16'h2222; bus.host_oe = 1'b1;
        bus.OTG_CS_N = 1'b0;
        @(negedge clk);
        bus.OTG_WR_N = 1'b0;
        repeat (SYNC + 2) @(negedge clk);
        bus.OTG_RST_N = 1'b0;
        repeat (2) @(negedge clk);
        bus.OTG_RST_N = 1'b1;
        repeat (SYNC + 2) @(negedge clk);
        bus.OTG_WR_N = 1'b1;
        repeat (SYNC + 2) @(negedge clk);
        bus.OTG_CS_N = 1'b1; bus.host_oe = 1'b0;
        repeat (SYNC + 2) @(negedge clk);
        check("srst_oe", bus.dev_oe, 1'b0);
        read_chk("srst_addr", 2'b10, 16'h0000);
        host_write(2'b10, 16'h0020, 1'b0);
        read_chk("srst_ram_kept", 2'b00, 16'h1111);

        // Reset_n during RD_DRIVE releases the bus immediately.
        bus.OTG_ADDR = 2'b10; bus.OTG_CS_N = 1'b0;
        @(negedge clk);
        bus.OTG_RD_N = 1'b0;
        repeat (SYNC + 3) @(negedge clk);
        check("drive_before_rst", bus.dev_oe, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rst_oe", bus.dev_oe, 1'b0);
        bus.OTG_RD_N = 1'b1; bus.OTG_CS_N = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (SYNC + 3) @(negedge clk);

        // Randomized traffic against the reference model.
        m_mem.delete();
        m_addr = 0; m_d2h = 16'h0; m_d2h_known = 0; m_full = 0; m_ovr = 0;
        m_h2d_valid = 0; m_h2d = 16'h0;
        for (int n = 0; n < 90; n++) begin
            case ($urandom_range(0, 7))
                0: begin
                    if ($urandom_range(0, 5) == 0) m_addr = AMOD - 2 * $urandom_range(1, 2);
                    else m_addr = 16'h0100 + 2 * $urandom_range(0, 7);
                    host_write(2'b10, 16'(m_addr), 1'b0);
                end
                1: begin
                    v = 16'($urandom);
                    host_write(2'b00, v, 1'b0);
                    m_mem[m_addr / 2] = v;
                    m_addr = (m_addr + 2) % AMOD;
                end
                2: begin
                    host_read(2'b00, rd, oe, 1'b0, 16'h0);
                    check("rnd_data_oe", oe, 1'b1);
                    if (m_mem.exists(m_addr / 2)) check("rnd_data", rd, m_mem[m_addr / 2]);
                    m_addr = (m_addr + 2) % AMOD;
                end
                3: read_chk("rnd_addr", 2'b10, 16'(m_addr));
                4: begin
                    v = 16'($urandom);
                    host_write(2'b01, v, 1'b0);
                    m_h2d = v; m_h2d_valid = 1;
                    check("rnd_h2d_valid", h2d_valid, 1'b1);
                    check("rnd_h2d_data", h2d_data, m_h2d);
                    if ($urandom_range(0, 1) == 1) begin
                        h2d_ack = 1'b1;
                        @(negedge clk);
                        h2d_ack = 1'b0;
                        @(negedge clk);
                        m_h2d_valid = 0;
                        check("rnd_h2d_ack", h2d_valid, 1'b0);
                    end
                end
                5: begin
                    v = 16'($urandom);
                    d2h_post(v);
                    if (m_full) m_ovr = 1;
                    m_full = 1; m_d2h = v; m_d2h_known = 1;
                    check("rnd_int_post", otg_int, 1'b1);
                    @(negedge clk);
                end
                6: begin
                    exp_w = 16'h0;
                    exp_w[2] = m_h2d_valid;
                    exp_w[1] = m_ovr;
                    exp_w[0] = m_full;
                    read_chk("rnd_status", 2'b11, exp_w);
                    m_ovr = 0;
                end
                default: begin
                    host_read(2'b01, rd, oe, 1'b0, 16'h0);
                    check("rnd_mbx_oe", oe, 1'b1);
                    if (m_d2h_known) check("rnd_mbx", rd, m_d2h);
                    m_full = 0;
                    check("rnd_int_read", otg_int, 1'b0);
                end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
